// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and helpers for the FIR filter chain
//               (FIR stage and the decimating output buffer).
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Native sample width of the FIR output stream.
    localparam int c_DATA_WIDTH = 8;

    // Default decimation factor applied after the FIR stage.
    localparam int c_DECIM = 4;

    // Ceiling log2, usable in constant expressions; fir_clog2(1) == 0.
    function automatic int fir_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock show-ahead FIFO. A push into a full FIFO is
//               dropped (and flagged on o_drop) unless a pop happens on the
//               same edge, in which case both take place.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_pop,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    output logic [fir_clog2(DEPTH):0]    o_level,
    output logic                         o_drop
);

    localparam int c_AW = fir_clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic [c_AW-1:0]       w_wr_ptr_nxt;
    logic [c_AW-1:0]       w_rd_ptr_nxt;
    logic [c_LW-1:0]       w_level_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr;

    assign w_full  = (r_level == c_LW'(DEPTH));
    assign w_empty = (r_level == '0);
    // A pop request while empty is meaningless and ignored.
    assign w_rd    = i_pop & ~w_empty & ~i_flush;
    // When full, the write lands in the slot being vacated by a same-edge pop.
    assign w_wr    = i_push & ~i_flush & (~w_full | w_rd);
    assign o_drop  = i_push & ~i_flush & w_full & ~w_rd;

    assign o_valid = ~w_empty;
    assign o_level = r_level;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Next pointer/level values; flush empties the FIFO without touching storage.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (i_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end else begin
            if (w_wr) w_wr_ptr_nxt = r_wr_ptr + c_AW'(1);
            if (w_rd) w_rd_ptr_nxt = r_rd_ptr + c_AW'(1);
            if (w_wr && !w_rd)      w_level_nxt = r_level + c_LW'(1);
            else if (!w_wr && w_rd) w_level_nxt = r_level - c_LW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
        end
    end

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/fir_decim_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_buffer
// Description : Decimates the FIR output stream by DECIM, buffers the result
//               in a small FIFO and hands it downstream over valid/ready.
//               Samples lost to a full FIFO are counted (saturating).
//               Build option FIR_DECIM_AVG_EN: push the boxcar average of each
//               group instead of its last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DECIM      = c_DECIM,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_en,
    input  logic [DATA_WIDTH-1:0]           y_in,
    input  logic                            flush,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [fir_clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [CNT_WIDTH-1:0]            overflow_cnt
);

    localparam int c_DEC_SH = fir_clog2(DECIM);
    // Keep at least one phase bit so DECIM=1 still has a legal vector.
    localparam int c_PH_W   = (c_DEC_SH < 1) ? 1 : c_DEC_SH;

    logic [c_PH_W-1:0]     r_phase;
    logic [c_PH_W-1:0]     w_phase_nxt;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;
    logic [CNT_WIDTH-1:0]  w_ovf_cnt_nxt;
    logic                  w_dec_push;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_push_data;

    assign w_dec_push = in_en & (r_phase == c_PH_W'(DECIM - 1));
    // A decimation strobe landing on a flush belongs to discarded history.
    assign w_push     = w_dec_push & ~flush;
    assign w_pop      = out_valid & out_ready;

    // Phase advances per accepted input sample and wraps at the group end.
    always_comb begin
        w_phase_nxt = r_phase;
        if (flush)           w_phase_nxt = '0;
        else if (w_dec_push) w_phase_nxt = '0;
        else if (in_en)      w_phase_nxt = r_phase + c_PH_W'(1);
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) r_phase <= '0;
        else     r_phase <= w_phase_nxt;
    end

`ifdef FIR_DECIM_AVG_EN
    localparam int c_ACC_W = DATA_WIDTH + c_DEC_SH;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_acc_nxt;
    logic [c_ACC_W-1:0] w_acc_sum;

    // Running group sum including the current sample; wide enough for DECIM full-scale inputs.
    always_comb begin
        w_acc_sum = r_acc + c_ACC_W'(y_in);
        w_acc_nxt = r_acc;
        if (flush || w_dec_push) w_acc_nxt = '0;
        else if (in_en)          w_acc_nxt = w_acc_sum;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) r_acc <= '0;
        else     r_acc <= w_acc_nxt;
    end

    // Divide by the power-of-two group size, truncating.
    assign w_push_data = DATA_WIDTH'(w_acc_sum >> c_DEC_SH);
`else
    // Pick mode: the last sample of each group is kept.
    assign w_push_data = y_in;
`endif

    // Saturating count of samples lost to a full FIFO; survives flush.
    always_comb begin
        w_ovf_cnt_nxt = r_ovf_cnt;
        if (w_drop && (r_ovf_cnt != '1)) w_ovf_cnt_nxt = r_ovf_cnt + CNT_WIDTH'(1);
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (rst) r_ovf_cnt <= '0;
        else     r_ovf_cnt <= w_ovf_cnt_nxt;
    end

    assign overflow_cnt = r_ovf_cnt;

    fir_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_buffer
// Description : Self-checking bench for fir_decim_buffer (DECIM=4, depth 8).
//               Honours FIR_DECIM_AVG_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_buffer;

    localparam int DW    = 8;
    localparam int DECIM = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_en;
    logic [DW-1:0] y_in;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_level;
    logic [CW-1:0] overflow_cnt;

    always #5 clk = ~clk;

    fir_decim_buffer #(
        .DATA_WIDTH (DW),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_en        (in_en),
        .y_in         (y_in),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending group samples, queued outputs, drop count.
    int mq[$];
    int grp[$];
    int m_ovf = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value produced by a completed group of DECIM samples.
    function automatic int group_value();
        int s;
        s = 0;
`ifdef FIR_DECIM_AVG_EN
        foreach (grp[i]) s += grp[i];
        return s / DECIM;
`else
        s = grp[DECIM-1];
        return s;
`endif
    endfunction

    // Expected output for a group of four consecutive ramp values ending at 'last'.
    function automatic int ramp_group(input int last);
`ifdef FIR_DECIM_AVG_EN
        return (4 * last - 6) / 4;
`else
        return last;
`endif
    endfunction

    task automatic model_step(input bit r, input bit f, input bit en, input int y, input bit rdy);
        bit pop;
        bit pv;
        int val;
        if (r) begin
            mq.delete();
            grp.delete();
            m_ovf = 0;
        end else begin
            pop = rdy && (mq.size() > 0);
            pv  = 1'b0;
            val = 0;
            if (en) begin
                grp.push_back(y);
                if (grp.size() == DECIM) begin
                    pv  = 1'b1;
                    val = group_value();
                    grp.delete();
                end
            end
            if (f) begin
                mq.delete();
                grp.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (pv) begin
                    if (mq.size() < DEPTH) mq.push_back(val);
                    else if (m_ovf < (1 << CW) - 1) m_ovf++;
                end
            end
        end
    endtask

    task automatic check_model();
        check("mdl_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
        check("mdl_level", int'(fifo_level), mq.size());
        check("mdl_data", int'(out_data), (mq.size() > 0) ? mq[0] : 0);
        check("mdl_ovf", int'(overflow_cnt), m_ovf);
    endtask

    // One clock: drive, update the model at the edge, then compare after it.
    task automatic cycle(input bit r, input bit f, input bit en, input int y, input bit rdy);
        rst       = r;
        flush     = f;
        in_en     = en;
        y_in      = y[7:0];
        out_ready = rdy;
        @(posedge clk);
        model_step(r, f, en, y, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        bit en;
        int y;
        bit rdy;
        int e_valid;
        int e_level;
        int e_data;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int last_data;
        int base_ovf;

        // Ramp table: output visible the cycle after each fourth sample, popped next.
        for (int i = 0; i < 16; i++) begin
            tbl[i].en      = 1'b1;
            tbl[i].y       = i;
            tbl[i].rdy     = 1'b1;
            tbl[i].e_valid = (i % 4 == 3) ? 1 : 0;
            tbl[i].e_level = (i % 4 == 3) ? 1 : 0;
            tbl[i].e_data  = (i % 4 == 3) ? ramp_group(i) : 0;
        end

        rst = 1'b1; flush = 1'b0; in_en = 1'b0; y_in = '0; out_ready = 1'b0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow_cnt), 0);
        check("rst_data", int'(out_data), 0);

        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, tbl[i].en, tbl[i].y, tbl[i].rdy);
            check("tbl_valid", int'(out_valid), tbl[i].e_valid);
            check("tbl_level", int'(fifo_level), tbl[i].e_level);
            check("tbl_data", int'(out_data), tbl[i].e_data);
        end

        // Full-scale constant input must not wrap the accumulator.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 255, 1);
        check("const255", int'(out_data), 255);
        cycle(0, 0, 0, 0, 1);

        // Nine pushes into a depth-8 FIFO with consumer stalled.
        for (int k = 0; k < 36; k++) cycle(0, 0, 1, k, 0);
        check("ovf_level", int'(fifo_level), 8);
        check("ovf_cnt", int'(overflow_cnt), 1);
        for (int k = 0; k < 8; k++) begin
            check("drain_data", int'(out_data), ramp_group(4 * k + 3));
            cycle(0, 0, 0, 0, 1);
        end
        check("drain_empty", int'(out_valid), 0);
        check("drain_level", int'(fifo_level), 0);

        // Full FIFO with a pop on the push cycle: both happen, nothing dropped.
        for (int j = 0; j < 32; j++) cycle(0, 0, 1, 100 + j, 0);
        check("full_level", int'(fifo_level), 8);
        base_ovf = int'(overflow_cnt);
        cycle(0, 0, 1, 200, 0);
        cycle(0, 0, 1, 201, 0);
        cycle(0, 0, 1, 202, 0);
        cycle(0, 0, 1, 203, 1);
        check("fullpp_level", int'(fifo_level), 8);
        check("fullpp_ovf", int'(overflow_cnt), base_ovf);
        check("fullpp_ovf1", base_ovf, 1);
        last_data = -1;
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 1);
        last_data = int'(out_data);
`ifdef FIR_DECIM_AVG_EN
        check("fullpp_tail", last_data, 201);
`else
        check("fullpp_tail", last_data, 203);
`endif
        cycle(0, 0, 0, 0, 1);
        check("fullpp_empty", int'(out_valid), 0);

        // Alternating in_en: phase freezes, so a push lands every eighth clock.
        for (int j = 0; j < 16; j++) begin
            cycle(0, 0, (j % 2 == 0), j, 1);
            check("toggle_valid", int'(out_valid), (j == 6 || j == 14) ? 1 : 0);
`ifdef FIR_DECIM_AVG_EN
            if (j == 6)  check("toggle_data", int'(out_data), 3);
            if (j == 14) check("toggle_data", int'(out_data), 11);
`else
            if (j == 6)  check("toggle_data", int'(out_data), 6);
            if (j == 14) check("toggle_data", int'(out_data), 14);
`endif
        end

        // Three buffered samples plus partial phase 2, then flush.
        for (int j = 0; j < 14; j++) cycle(0, 0, 1, 50 + j, 0);
        check("pre_flush_level", int'(fifo_level), 3);
        cycle(0, 1, 1, 0, 0);
        check("flush_valid", int'(out_valid), 0);
        check("flush_level", int'(fifo_level), 0);
        check("flush_ovf_kept", int'(overflow_cnt), 1);
        for (int j = 0; j < 3; j++) begin
            cycle(0, 0, 1, 10 + j, 0);
            check("flush_refill_idle", int'(out_valid), 0);
        end
        cycle(0, 0, 1, 13, 0);
        check("flush_refill_valid", int'(out_valid), 1);
        check("flush_refill_level", int'(fifo_level), 1);

        // Same buildup, cleared by reset instead.
        cycle(0, 0, 0, 0, 1);
        for (int j = 0; j < 14; j++) cycle(0, 0, 1, 70 + j, 0);
        check("pre_rst_level", int'(fifo_level), 3);
        cycle(1, 0, 1, 0, 0);
        check("rst2_valid", int'(out_valid), 0);
        check("rst2_level", int'(fifo_level), 0);
        check("rst2_ovf", int'(overflow_cnt), 0);
        for (int j = 0; j < 3; j++) begin
            cycle(0, 0, 1, 20 + j, 0);
            check("rst_refill_idle", int'(out_valid), 0);
        end
        cycle(0, 0, 1, 23, 0);
        check("rst_refill_valid", int'(out_valid), 1);
`ifdef FIR_DECIM_AVG_EN
        check("rst_refill_data", int'(out_data), 21);
`else
        check("rst_refill_data", int'(out_data), 23);
`endif

        // Randomised traffic against the model: stalled consumer first, then eager.
        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit f;
            bit en;
            bit rdy;
            r   = ($urandom_range(0, 299) == 0);
            f   = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rdy = (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cycle(r, f, en, int'($urandom_range(0, 255)), rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Downstream stage of the FIR filter. Consumes the 8-bit filtered stream `y_out` and decimates it by DECIM.
- Buffers decimated samples in a small synchronous FIFO.
- Presents them to the next consumer over a valid/ready handshake.
- Absorbs consumer back-pressure and counts samples dropped on overflow.

Parameters:
- DATA_WIDTH, 8, sample width; matches the FIR output.
- DECIM, 4, decimation factor; power of two, range 1..256.
- FIFO_DEPTH, 8, FIFO entries; power of two, range 2..256.
- CNT_WIDTH, 16, width of the overflow counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_en  in  1  input sample strobe; tied high when the FIR produces one sample per clk.
- y_in  in  DATA_WIDTH  filtered sample from the FIR output.
- flush  in  1  synchronous clear of datapath state.
- out_data  out  DATA_WIDTH  head-of-FIFO sample; valid only when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the sample.
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of stored entries.
- overflow_cnt  out  CNT_WIDTH  saturating count of dropped samples.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over all other inputs and clears:
  - phase counter and accumulator,
  - FIFO pointers,
  - out_valid=0, fifo_level=0, overflow_cnt=0.
  - out_data is then don't-care; it is driven to 0 while empty.
- Reset mid-operation discards all buffered samples and any partial decimation phase. The first post-reset decimated output uses samples 0..DECIM-1 counted after reset deasserts.
- Phase counter:
  - Range 0..DECIM-1; increments on each clk with in_en=1 and wraps to 0.
  - A decimation strobe (dec_push) occurs when in_en=1 and phase==DECIM-1.
  - in_en=0 freezes the phase counter.
- Pick mode (default): the pushed value is the y_in present on the dec_push cycle, i.e. the last sample of each group of DECIM.
- DECIM=1: every in_en sample is pushed.
- FIFO:
  - Write and read pointers, clog2(FIFO_DEPTH) bits each, wrap modulo depth.
  - Occupancy is tracked in fifo_level.
  - push = dec_push; pop = out_valid & out_ready.
  - Show-ahead: out_data = mem[rd_ptr] combinationally from registered storage.
- Latency: a sample pushed at edge N is visible with out_valid=1 after edge N, when the FIFO was empty.
- Full (level==FIFO_DEPTH) with push and no pop:
  - sample is dropped; FIFO contents are unchanged;
  - overflow_cnt increments, saturating at 2^CNT_WIDTH-1.
- Full with push and pop in the same cycle: both occur; level stays FIFO_DEPTH; no drop.
- Empty with pop requested: impossible, since out_valid=0; out_ready is ignored.
- Empty with push: level becomes 1.
- Handshake rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts without a pop, flush or rst.
- flush=1 (rst=0):
  - clears pointers, level, phase and accumulator the same edge;
  - overflow_cnt is retained;
  - a dec_push coincident with flush is discarded.

Optional Feature:
- Macro: FIR_DECIM_AVG_EN.
- Defined: boxcar-average mode.
  - Accumulator width is DATA_WIDTH+clog2(DECIM) bits and sums every in_en sample.
  - On dec_push the pushed value is (acc + y_in) >> clog2(DECIM), truncating with no rounding.
  - The accumulator is cleared on the same edge; it is also cleared by rst and flush.
- Undefined: pick mode only; no accumulator logic is synthesized.

Decomposition:
- Shared package fir_pkg:
  - DATA_WIDTH default, a clog2 constant function, a default DECIM constant.
  - This package is also used by the FIR stage.
- One sub-module, fir_sync_fifo:
  - Parameterized storage, pointers and level.
  - Push, pop and full-drop logic with simultaneous push/pop handling.
- The top level holds the phase counter, the optional accumulator and overflow_cnt.

Test Plan:
- DECIM=4, in_en=1, out_ready=1, y_in ramp 0,1,2,... -> out_data sequence 3,7,11,15. Each sample appears one cycle after its dec_push; level never exceeds 1.
- Same ramp with FIR_DECIM_AVG_EN defined -> out_data 1,5,9,13. Constant y_in=255 -> 255, confirming no overflow from accumulator width.
- out_ready=0, 9 decimated pushes, FIFO_DEPTH=8 -> level=8, overflow_cnt=1. Then out_ready=1 drains 3,7,...,31 in order; the ninth value 35 is absent.
- FIFO full with out_ready=1 on a dec_push cycle -> level stays 8, overflow_cnt unchanged, the new sample is the tail entry.
- in_en toggling 1,0,1,0,... with DECIM=2 -> phase holds on in_en=0; a push occurs every fourth clk.
- Three samples buffered, partial phase=2:
  - rst pulse -> out_valid=0, level=0, overflow_cnt=0; the next output appears after 4 fresh in_en samples.
  - Same stimulus with flush instead of rst -> identical, except overflow_cnt is retained.
